// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add controller: sequences external point_double / point_add units
// to compute R = k*G, handling infinity, y=0, Q==G and Q==-G in the controller itself.
module scalar_mult_ctrl #(
    parameter logic [255:0] P          = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F,
    parameter int           W          = 256,
    parameter int           DONE_GUARD = 2
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [W-1:0] k_i,
    input  logic [W-1:0] gx_i,
    input  logic [W-1:0] gy_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         inf_o,
    output logic [W-1:0] rx_o,
    output logic [W-1:0] ry_o,
    output logic         dblReset_o,
    output logic [W-1:0] dblPx_o,
    output logic [W-1:0] dblPy_o,
    input  logic         dblDone_i,
    input  logic [W-1:0] dblRx_i,
    input  logic [W-1:0] dblRy_i,
    output logic         addReset_o,
    output logic [W-1:0] addPx_o,
    output logic [W-1:0] addPy_o,
    output logic [W-1:0] addQx_o,
    output logic [W-1:0] addQy_o,
    input  logic         addDone_i,
    input  logic [W-1:0] addRx_i,
    input  logic [W-1:0] addRy_i
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam int GW = (DONE_GUARD < 1) ? 1 : $clog2(DONE_GUARD + 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(DONE_GUARD);

    if (DONE_GUARD < 0 || P[0] == 1'b0) begin : g_param_check
        $error("scalar_mult_ctrl: DONE_GUARD must be >= 0 and P must be an odd prime");
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_SCAN,
        S_DBL_RST,
        S_DBL_WAIT,
        S_ADD_CHK,
        S_ADD_RST,
        S_ADD_WAIT,
        S_NEXT,
        S_FIN
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    kReg_q, kReg_d;
    logic [W-1:0]    gx_q, gx_d;
    logic [W-1:0]    gy_q, gy_d;
    logic [W-1:0]    qx_q, qx_d;
    logic [W-1:0]    qy_q, qy_d;
    logic            qInf_q, qInf_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [GW-1:0]   guard_q, guard_d;
    logic            dblToNext_q, dblToNext_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            inf_q, inf_d;
    logic [W-1:0]    rx_q, rx_d;
    logic [W-1:0]    ry_q, ry_d;
    logic            dblReset_q, dblReset_d;
    logic            addReset_q, addReset_d;

    logic            curBit;
    logic            qIsG;
    logic            qIsNegG;

    assign curBit  = kReg_q[idx_q];
    assign qIsG    = (qx_q == gx_q) && (qy_q == gy_q);
    assign qIsNegG = (qx_q == gx_q) && (qy_q != gy_q);

    // dblToNext marks a doubling issued from ADD_CHK because Q==G; its result
    // completes the add step, so the FSM returns to NEXT instead of ADD_CHK.
    always_comb begin
        state_d     = state_q;
        kReg_d      = kReg_q;
        gx_d        = gx_q;
        gy_d        = gy_q;
        qx_d        = qx_q;
        qy_d        = qy_q;
        qInf_d      = qInf_q;
        idx_d       = idx_q;
        guard_d     = guard_q;
        dblToNext_d = dblToNext_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        inf_d       = inf_q;
        rx_d        = rx_q;
        ry_d        = ry_q;
        dblReset_d  = dblReset_q;
        addReset_d  = addReset_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    kReg_d      = k_i;
                    gx_d        = gx_i;
                    gy_d        = gy_i;
                    qx_d        = '0;
                    qy_d        = '0;
                    qInf_d      = 1'b1;
                    idx_d       = IW'(W - 1);
                    dblToNext_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = S_SCAN;
                end
            end

            S_SCAN: begin
                if (curBit) begin
                    qx_d   = gx_q;
                    qy_d   = gy_q;
                    qInf_d = 1'b0;
                    if (idx_q == '0) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = S_DBL_RST;
                    end
                end else if (idx_q == '0) begin
                    qInf_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end

            S_DBL_RST: begin
                if (qInf_q || (qy_q == '0)) begin
                    qInf_d      = 1'b1;
                    qx_d        = '0;
                    qy_d        = '0;
                    dblToNext_d = 1'b0;
                    state_d     = dblToNext_q ? S_NEXT : S_ADD_CHK;
                end else begin
                    dblReset_d = 1'b0;
                    guard_d    = GUARD_LOAD;
                    state_d    = S_DBL_WAIT;
                end
            end

            S_DBL_WAIT: begin
                if (guard_q != '0) begin
                    guard_d = guard_q - 1'b1;
                end else if (dblDone_i) begin
                    qx_d        = dblRx_i;
                    qy_d        = dblRy_i;
                    qInf_d      = 1'b0;
                    dblReset_d  = 1'b1;
                    dblToNext_d = 1'b0;
                    state_d     = dblToNext_q ? S_NEXT : S_ADD_CHK;
                end
            end

            S_ADD_CHK: begin
                if (!curBit) begin
                    state_d = S_NEXT;
                end else if (qInf_q) begin
                    qx_d    = gx_q;
                    qy_d    = gy_q;
                    qInf_d  = 1'b0;
                    state_d = S_NEXT;
                end else if (qIsG) begin
                    dblToNext_d = 1'b1;
                    state_d     = S_DBL_RST;
                end else if (qIsNegG) begin
                    qInf_d  = 1'b1;
                    qx_d    = '0;
                    qy_d    = '0;
                    state_d = S_NEXT;
                end else begin
                    state_d = S_ADD_RST;
                end
            end

            S_ADD_RST: begin
                addReset_d = 1'b0;
                guard_d    = GUARD_LOAD;
                state_d    = S_ADD_WAIT;
            end

            S_ADD_WAIT: begin
                if (guard_q != '0) begin
                    guard_d = guard_q - 1'b1;
                end else if (addDone_i) begin
                    qx_d       = addRx_i;
                    qy_d       = addRy_i;
                    qInf_d     = 1'b0;
                    addReset_d = 1'b1;
                    state_d    = S_NEXT;
                end
            end

            S_NEXT: begin
                if (idx_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q - 1'b1;
                    state_d = S_DBL_RST;
                end
            end

            S_FIN: begin
                rx_d    = qInf_q ? '0 : qx_q;
                ry_d    = qInf_q ? '0 : qy_q;
                inf_d   = qInf_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            kReg_q      <= '0;
            gx_q        <= '0;
            gy_q        <= '0;
            qx_q        <= '0;
            qy_q        <= '0;
            qInf_q      <= 1'b1;
            idx_q       <= '0;
            guard_q     <= '0;
            dblToNext_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            inf_q       <= 1'b0;
            rx_q        <= '0;
            ry_q        <= '0;
            dblReset_q  <= 1'b1;
            addReset_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            kReg_q      <= kReg_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            qx_q        <= qx_d;
            qy_q        <= qy_d;
            qInf_q      <= qInf_d;
            idx_q       <= idx_d;
            guard_q     <= guard_d;
            dblToNext_q <= dblToNext_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            inf_q       <= inf_d;
            rx_q        <= rx_d;
            ry_q        <= ry_d;
            dblReset_q  <= dblReset_d;
            addReset_q  <= addReset_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign inf_o      = inf_q;
    assign rx_o       = rx_q;
    assign ry_o       = ry_q;
    assign dblReset_o = dblReset_q;
    assign dblPx_o    = qx_q;
    assign dblPy_o    = qy_q;
    assign addReset_o = addReset_q;
    assign addPx_o    = qx_q;
    assign addPy_o    = qy_q;
    assign addQx_o    = gx_q;
    assign addQy_o    = gy_q;

endmodule
